// File: rtl/gate_identifier.sv
// gate_identifier
//   Drives the four {a,b} input vectors into an external 2-input gate,
//   samples its output for each one, and decodes which primitive function
//   the gate implements.
//
//   Parameter:
//     SETTLE_CYCLES  cycles each vector is held before dut_y is sampled
//                    (1..255; 2..255 when the stability check is built in)
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     start      request an identification run (honoured only in IDLE)
//     dut_y      output of the gate-under-test
//     dut_a      stimulus a to the gate-under-test
//     dut_b      stimulus b to the gate-under-test
//     busy       high while a run is in progress
//     done       one-cycle pulse when truth/gate_code are updated
//     truth      truth[i] = dut_y sampled with {dut_a,dut_b} = i
//     gate_code  0 unknown, 1 NOT(a), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NAND
//     unstable   set with done when any vector's output was not steady
//
//   Optional feature macro: GATE_ID_STABILITY_CHECK_EN
//     When defined, dut_y is also sampled one edge before each main sample;
//     a disagreement sets unstable and forces gate_code to 0.
//     When undefined, unstable is tied to 0.

module gate_identifier #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_code,
  output logic       unstable
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    DECODE = 2'd2
  } state_t;

  // Counter value at which the main sample of the current vector is taken.
  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  // Elaboration-time range check of the settle time.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gate_identifier: SETTLE_CYCLES must be in 1..255");
  end

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] k;
  logic [3:0] truth_shadow;

  // Map a captured truth table onto the supported gate primitives.
  function automatic logic [2:0] decode(input logic [3:0] t);
    logic [2:0] code;
    case (t)
      4'b0011: code = 3'd1;  // NOT(a)
      4'b1000: code = 3'd2;  // AND
      4'b1110: code = 3'd3;  // OR
      4'b0110: code = 3'd4;  // XOR
      4'b0001: code = 3'd5;  // NOR
      4'b0111: code = 3'd6;  // NAND
      default: code = 3'd0;  // constants, b-only, implication, ...
    endcase
    return code;
  endfunction

`ifdef GATE_ID_STABILITY_CHECK_EN
  // Counter value one edge before the main sample.
  localparam logic [7:0] PRE_CNT = 8'(SETTLE_CYCLES - 2);

  if (SETTLE_CYCLES < 2) begin : g_bad_settle_stab
    $error("gate_identifier: stability check needs SETTLE_CYCLES >= 2");
  end

  logic pre_y;
  logic unstable_shadow;
  logic unstable_q;

  assign unstable = unstable_q;
`else
  assign unstable = 1'b0;
`endif

  // Run sequencer: vector stimulus, sampling, decode and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      k            <= 2'd0;
      truth_shadow <= 4'b0000;
      dut_a        <= 1'b0;
      dut_b        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      truth        <= 4'b0000;
      gate_code    <= 3'd0;
`ifdef GATE_ID_STABILITY_CHECK_EN
      pre_y           <= 1'b0;
      unstable_shadow <= 1'b0;
      unstable_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dut_a <= 1'b0;
          dut_b <= 1'b0;
          if (start) begin
            state <= APPLY;
            k     <= 2'd0;
            cnt   <= 8'd0;
            busy  <= 1'b1;
`ifdef GATE_ID_STABILITY_CHECK_EN
            unstable_shadow <= 1'b0;
`endif
          end
        end

        APPLY: begin
`ifdef GATE_ID_STABILITY_CHECK_EN
          if (cnt == PRE_CNT) begin
            pre_y <= dut_y;
          end
`endif
          if (cnt == LAST_CNT) begin
            truth_shadow[k] <= dut_y;
`ifdef GATE_ID_STABILITY_CHECK_EN
            if (pre_y != dut_y) begin
              unstable_shadow <= 1'b1;
            end
`endif
            cnt <= 8'd0;
            if (k == 2'd3) begin
              state <= DECODE;
            end else begin
              k              <= k + 2'd1;
              {dut_a, dut_b} <= k + 2'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        DECODE: begin
          truth <= truth_shadow;
`ifdef GATE_ID_STABILITY_CHECK_EN
          gate_code  <= unstable_shadow ? 3'd0 : decode(truth_shadow);
          unstable_q <= unstable_shadow;
`else
          gate_code <= decode(truth_shadow);
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          dut_a <= 1'b0;
          dut_b <= 1'b0;
          k     <= 2'd0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
